// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV64I-subset control unit:
// opcodes, FSM states and datapath select values.
package multicycle_control_unit_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_ALU_WB   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] M2R_ALU  = 2'd0;
   localparam logic [1:0] M2R_MDR  = 2'd1;
   localparam logic [1:0] M2R_LINK = 2'd2;

   localparam logic [1:0] PCS_ALU = 2'd0;
   localparam logic [1:0] PCS_OUT = 2'd1;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and single memory port, trapping on bad opcodes or bus hangs.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int ENABLE_JAL  = 1,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] Opcode,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic [1:0] MemtoReg,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [3:0] state_dbg
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_cause;
   logic [1:0]       w_cause;
   logic             w_timeout;

   // Completion beats timeout: w_timeout is only ever consulted with mem_ready low.
   assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                      (r_cnt == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      w_next   = r_state;
      w_cause  = r_cause;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = PCS_ALU;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ALUOp    = ALUOP_ADD;
      RegWrite = 1'b0;
      MemtoReg = M2R_ALU;
      if (rst_n) begin
         unique case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               ALUSrcB = 2'd1;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  w_next  = S_DECODE;
               end else if (w_timeout) begin
                  w_next  = S_TRAP;
                  w_cause = CAUSE_TIMEOUT;
               end
            end
            S_DECODE: begin
               ALUSrcA = 2'd2;
               ALUSrcB = 2'd2;
               case (Opcode)
                  OP_R:         w_next = S_EXEC_R;
                  OP_ADDI:      w_next = S_EXEC_I;
                  OP_LD, OP_SD: w_next = S_MEM_ADDR;
                  OP_BEQ:       w_next = S_BRANCH;
                  OP_JAL: begin
                     if (ENABLE_JAL != 0) begin
                        w_next = S_JAL;
                     end else begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_ILLEGAL;
                     end
                  end
                  default: begin
                     w_next  = S_TRAP;
                     w_cause = CAUSE_ILLEGAL;
                  end
               endcase
            end
            S_EXEC_R: begin
               ALUSrcA = 2'd1;
               ALUOp   = ALUOP_FUNCT;
               w_next  = S_ALU_WB;
            end
            S_EXEC_I: begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd2;
               w_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
               RegWrite = 1'b1;
               w_next   = S_FETCH;
            end
            S_MEM_ADDR: begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd2;
               w_next  = (Opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               IorD    = 1'b1;
               if (mem_ready) begin
                  w_next = S_MEM_WB;
               end else if (w_timeout) begin
                  w_next  = S_TRAP;
                  w_cause = CAUSE_TIMEOUT;
               end
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_MDR;
               w_next   = S_FETCH;
            end
            S_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               IorD    = 1'b1;
               if (mem_ready) begin
                  w_next = S_FETCH;
               end else if (w_timeout) begin
                  w_next  = S_TRAP;
                  w_cause = CAUSE_TIMEOUT;
               end
            end
            S_BRANCH: begin
               ALUSrcA = 2'd1;
               ALUOp   = ALUOP_SUB;
               PCSrc   = PCS_OUT;
               PCWrite = Zero;
               w_next  = S_FETCH;
            end
            S_JAL: begin
               PCWrite  = 1'b1;
               PCSrc    = PCS_OUT;
               RegWrite = 1'b1;
               MemtoReg = M2R_LINK;
               w_next   = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_next;
         r_cause <= w_cause;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (!mem_ready && is_wait_state(r_state)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign trap       = (r_state == S_TRAP);
   assign trap_cause = r_cause;
   assign state_dbg  = r_state;

endmodule
